// File: rtl/yolo_params_pkg.sv
// Shared sizing parameters and loader state encoding for the convolution front-end.
package yolo_params_pkg;

  localparam int IP_DATA_WIDTH = 8;
  localparam int IFMAP_SIZE    = 5;
  localparam int FILTER_SIZE   = 3;
  localparam int OFMAP_SIZE    = IFMAP_SIZE - FILTER_SIZE + 1;

  typedef enum logic [2:0] {
    IDLE,
    FILT,
    IMAP,
    HOLD,
    DRAIN
  } loader_state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major position counter over a square of run-time selectable edge length.
module raster_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W:0]   edge_size,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             tc
);

  logic [CNT_W:0] last_idx;
  logic           col_end;
  logic           row_end;

  assign last_idx = edge_size - (CNT_W+1)'(1);
  assign col_end  = ({1'b0, col} == last_idx);
  assign row_end  = ({1'b0, row} == last_idx);
  assign tc       = col_end && row_end;

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ifmap_loader.sv
// Assembles a weight/pixel word stream into parallel filter and ifmap arrays
// and holds the finished tile until the convolution capture logic takes it.
module ifmap_loader
  import yolo_params_pkg::*;
#(
  parameter int IP_DATA_WIDTH = yolo_params_pkg::IP_DATA_WIDTH,
  parameter int IFMAP_SIZE    = yolo_params_pkg::IFMAP_SIZE,
  parameter int FILTER_SIZE   = yolo_params_pkg::FILTER_SIZE
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic [IP_DATA_WIDTH-1:0]                                 in_data,
  input  logic                                                     in_valid,
  output logic                                                     in_ready,
  input  logic                                                     in_last,
  input  logic                                                     keep_filter,
  output logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0] ifmap,
  output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter,
  output logic                                                     tile_valid,
  input  logic                                                     tile_ready,
  output logic                                                     frame_err
);

  localparam int CNT_W = $clog2(IFMAP_SIZE);
  localparam int FW    = $clog2(FILTER_SIZE);
  localparam logic [CNT_W:0] I_EDGE = (CNT_W+1)'(IFMAP_SIZE);
  localparam logic [CNT_W:0] F_EDGE = (CNT_W+1)'(FILTER_SIZE);

  loader_state_t    state, next_state;
  logic             filter_loaded;
  logic             accept;
  logic             cnt_clear, cnt_inc, cnt_tc;
  logic [CNT_W:0]   edge_size;
  logic [CNT_W-1:0] row, col;
  logic             wr_filt, wr_imap, set_loaded, clr_loaded, err;

  assign accept     = in_valid && in_ready;
  assign tile_valid = (state == HOLD);
  // The first beat is taken in IDLE at (0,0), so wrap size only matters once in FILT/IMAP.
  assign edge_size  = (state == FILT) ? F_EDGE : I_EDGE;

  raster_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .edge_size(edge_size),
    .row      (row),
    .col      (col),
    .tc       (cnt_tc)
  );

  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    wr_filt    = 1'b0;
    wr_imap    = 1'b0;
    set_loaded = 1'b0;
    clr_loaded = 1'b0;
    err        = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (keep_filter && filter_loaded) begin
          wr_imap    = 1'b1;
          next_state = IMAP;
        end else begin
          wr_filt    = 1'b1;
          clr_loaded = 1'b1;
          next_state = FILT;
        end
        cnt_inc = 1'b1;
        if (in_last) begin
          err        = 1'b1;
          clr_loaded = 1'b1;
          cnt_inc    = 1'b0;
          cnt_clear  = 1'b1;
          next_state = IDLE;
        end
      end
      FILT: if (accept) begin
        wr_filt = 1'b1;
        if (in_last) begin
          err        = 1'b1;
          clr_loaded = 1'b1;
          cnt_clear  = 1'b1;
          next_state = IDLE;
        end else if (cnt_tc) begin
          set_loaded = 1'b1;
          cnt_clear  = 1'b1;
          next_state = IMAP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      IMAP: if (accept) begin
        wr_imap = 1'b1;
        if (cnt_tc) begin
          cnt_clear  = 1'b1;
          err        = !in_last;
          next_state = in_last ? HOLD : DRAIN;
        end else if (in_last) begin
          err        = 1'b1;
          clr_loaded = 1'b1;
          cnt_clear  = 1'b1;
          next_state = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HOLD:  if (tile_ready) next_state = IDLE;
      DRAIN: if (accept && in_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      frame_err     <= 1'b0;
      filter_loaded <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state != HOLD);
      frame_err <= err;
      if (set_loaded)      filter_loaded <= 1'b1;
      else if (clr_loaded) filter_loaded <= 1'b0;
    end
  end

  // NOTE: the arrays are plain registers driving convolution directly, so they take the async reset too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifmap  <= '0;
      filter <= '0;
    end else begin
      if (wr_imap) ifmap[row][col] <= in_data;
      if (wr_filt) filter[row[FW-1:0]][col[FW-1:0]] <= in_data;
    end
  end

endmodule
